tmds_encoder_mc: RTL and testbench

Multi-channel, pipelined TMDS encoder for the HDMI/DVI transmit path. Per channel: 8-bit transition minimisation, DC balancing against a running-disparity counter, 2-bit control symbols and 4-bit TERC4 data-island symbols. Sits between the pixel/timing generator and the 10:1 serialisers. Replaces the standalone combinational transition-minimisation stage with a registered encoder that is complete across all modes and channels.

---
 rtl/tmds_pkg.sv | 51 +++++
 rtl/tmds_qm_stage.sv | 47 ++++
 rtl/tmds_encoder_mc.sv | 85 ++++++++
 tb/tb_tmds_encoder_mc.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: symbol modes, control/TERC4 code tables, stage-1 bundle.
// Pure declarations; no timing or backpressure of its own.
package tmds_pkg;

  typedef enum logic [1:0] {
    MODE_CTRL  = 2'b00,
    MODE_VIDEO = 2'b01,
    MODE_TERC4 = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  // Symbols written as [9:0]; bit 0 leaves the serialiser first.
  localparam logic [9:0] CTRL_SYM_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_SYM_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_SYM_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_SYM_11 = 10'b1010101011;
  localparam logic [9:0] RESET_SYM   = CTRL_SYM_00;

  localparam logic [9:0] TERC4_TABLE [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  typedef struct packed {
    mode_e      mode;
    logic [1:0] ctrl;
    logic [3:0] nib;
    logic [8:0] qm;
  } s1_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    logic [9:0] s;
    unique case (c)
      2'b00:   s = CTRL_SYM_00;
      2'b01:   s = CTRL_SYM_01;
      2'b10:   s = CTRL_SYM_10;
      default: s = CTRL_SYM_11;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// One channel's transition-minimisation stage (XOR/XNOR chain), 1 clock, registered.
// Free-running: accepts one byte every clock, no stall.
module tmds_qm_stage
  import tmds_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  mode_e      mode_i,
  input  logic [7:0] data_i,
  input  logic [1:0] ctrl_i,
  output s1_t        s1_o
);

  s1_t        s1_d, s1_q;
  logic [3:0] ones;
  logic       use_xnor;

  assign ones = popcount8(data_i);

  always_comb begin
    logic b;
    b        = data_i[0];
    use_xnor = (ones > 4'd4) || (ones == 4'd4 && !data_i[0]);
    s1_d     = '0;
    s1_d.mode  = mode_i;
    s1_d.ctrl  = ctrl_i;
    s1_d.nib   = data_i[3:0];
    s1_d.qm[0] = b;
    for (int i = 1; i < 8; i++) begin
      b = use_xnor ? ~(b ^ data_i[i]) : (b ^ data_i[i]);
      s1_d.qm[i] = b;
    end
    s1_d.qm[8] = ~use_xnor;
  end

  // Reset state decodes to the control 00 symbol downstream.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_q <= '{mode: MODE_CTRL, ctrl: 2'b00, nib: 4'h0, qm: 9'h0};
    end else begin
      s1_q <= s1_d;
    end
  end

  assign s1_o = s1_q;

endmodule

// File: rtl/tmds_encoder_mc.sv
// Multi-channel TMDS encoder: video/control/TERC4 symbols, 2-clock latency.
// No handshake: one symbol per channel per clock, never stalls.
module tmds_encoder_mc
  import tmds_pkg::*;
#(
  parameter int NUM_CH = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic [1:0]           mode_in,
  input  logic [NUM_CH*8-1:0]  data_in,
  input  logic [NUM_CH*2-1:0]  ctrl_in,
  output logic [NUM_CH*10-1:0] tmds_out
);

  s1_t               s1    [NUM_CH];
  logic [9:0]        sym_d [NUM_CH];
  logic [9:0]        sym_q [NUM_CH];
  logic signed [5:0] cnt_d [NUM_CH];
  logic signed [5:0] cnt_q [NUM_CH];

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    tmds_qm_stage u_qm (
      .clk_i   (clk_in),
      .rst_n_i (rst_n_in),
      .mode_i  (mode_e'(mode_in)),
      .data_i  (data_in[ch*8 +: 8]),
      .ctrl_i  (ctrl_in[ch*2 +: 2]),
      .s1_o    (s1[ch])
    );
    assign tmds_out[ch*10 +: 10] = sym_q[ch];
  end

  // Disparity decision uses the current cnt; diff is N1-N0 of q_m[7:0].
  always_comb begin
    logic [3:0]        n1;
    logic              q8;
    logic [7:0]        qm;
    logic signed [5:0] diff;
    n1   = '0;
    q8   = 1'b0;
    qm   = '0;
    diff = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      sym_d[ch] = RESET_SYM;
      cnt_d[ch] = '0;
      qm   = s1[ch].qm[7:0];
      q8   = s1[ch].qm[8];
      n1   = popcount8(qm);
      diff = $signed({1'b0, n1, 1'b0}) - 6'sd8;
      unique case (s1[ch].mode)
        MODE_VIDEO: begin
          if (cnt_q[ch] == 6'sd0 || n1 == 4'd4) begin
            sym_d[ch] = {~q8, q8, q8 ? qm : ~qm};
            cnt_d[ch] = q8 ? cnt_q[ch] + diff : cnt_q[ch] - diff;
          end else if ((cnt_q[ch] > 6'sd0 && n1 > 4'd4) ||
                       (cnt_q[ch] < 6'sd0 && n1 < 4'd4)) begin
            sym_d[ch] = {1'b1, q8, ~qm};
            cnt_d[ch] = cnt_q[ch] + (q8 ? 6'sd2 : 6'sd0) - diff;
          end else begin
            sym_d[ch] = {1'b0, q8, qm};
            cnt_d[ch] = cnt_q[ch] + diff - (q8 ? 6'sd0 : 6'sd2);
          end
        end
        MODE_TERC4: sym_d[ch] = TERC4_TABLE[s1[ch].nib];
        default:    sym_d[ch] = ctrl_sym(s1[ch].ctrl);
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        sym_q[ch] <= RESET_SYM;
        cnt_q[ch] <= '0;
      end
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        sym_q[ch] <= sym_d[ch];
        cnt_q[ch] <= cnt_d[ch];
      end
    end
  end

endmodule

// File: tb/tb_tmds_encoder_mc.sv
// Randomised bench for tmds_encoder_mc against a behavioural DVI/HDMI encoder model.
module tb_tmds_encoder_mc;

  localparam int NCH = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  mode_in = 2'b00;
  logic [23:0] data_in = '0;
  logic [5:0]  ctrl_in = '0;
  logic [29:0] tmds_out;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [2:0][9:0] sym;
    logic [2:0][7:0] dat;
    logic            vid;
    logic [2:0][7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   mcnt [NCH];

  logic [9:0] terc4_ref [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  tmds_encoder_mc #(.NUM_CH(NCH)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .mode_in  (mode_in),
    .data_in  (data_in),
    .ctrl_in  (ctrl_in),
    .tmds_out (tmds_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  // Reference encoder: one symbol for channel ch, updating that channel's disparity.
  function automatic logic [9:0] enc(int ch, logic [1:0] m, logic [7:0] d, logic [1:0] c);
    int         ones, n1, n0;
    logic       xn;
    logic [8:0] qm;
    logic [9:0] s;
    if (m == 2'b10) begin
      mcnt[ch] = 0;
      return terc4_ref[d[3:0]];
    end
    if (m != 2'b01) begin
      mcnt[ch] = 0;
      case (c)
        2'b00:   s = 10'b1101010100;
        2'b01:   s = 10'b0010101011;
        2'b10:   s = 10'b0101010100;
        default: s = 10'b1010101011;
      endcase
      return s;
    end
    ones = $countones(d);
    xn   = (ones > 4) || (ones == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i] ^ xn;
    qm[8] = !xn;
    n1 = $countones(qm[7:0]);
    n0 = 8 - n1;
    if (mcnt[ch] == 0 || n1 == n0) begin
      s = qm[8] ? {2'b01, qm[7:0]} : {2'b10, ~qm[7:0]};
      mcnt[ch] += qm[8] ? (n1 - n0) : (n0 - n1);
    end else if ((mcnt[ch] > 0 && n1 > n0) || (mcnt[ch] < 0 && n0 > n1)) begin
      s = {1'b1, qm[8], ~qm[7:0]};
      mcnt[ch] += 2 * int'(qm[8]) + (n0 - n1);
    end else begin
      s = {1'b0, qm[8], qm[7:0]};
      mcnt[ch] += (n1 - n0) - 2 * int'(!qm[8]);
    end
    return s;
  endfunction

  function automatic logic [7:0] decode(logic [9:0] s);
    logic [7:0] q, d;
    q = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = q[i] ^ q[i-1] ^ !s[8];
    return d;
  endfunction

  task automatic compare(input exp_t e);
    logic [9:0] got;
    int         c;
    for (int ch = 0; ch < NCH; ch++) begin
      got = tmds_out[ch*10 +: 10];
      c   = dut.cnt_q[ch];
      check_eq($sformatf("sym ch%0d", ch), int'(got), int'(e.sym[ch]));
      check_eq($sformatf("cnt ch%0d", ch), c, int'($signed(e.cnt[ch])));
      if (e.vid) begin
        check_eq($sformatf("decode ch%0d", ch), int'(decode(got)), int'(e.dat[ch]));
        check_eq($sformatf("cnt range ch%0d", ch), int'(c >= -16 && c <= 16), 1);
      end
    end
  endtask

  // Inputs change on the falling edge; the symbol for them is checked two falling edges later.
  task automatic cycle(input logic [1:0] m, input logic [23:0] d, input logic [5:0] c);
    exp_t e;
    @(negedge clk);
    if (exp_q.size() >= 2) compare(exp_q.pop_front());
    mode_in = m;
    data_in = d;
    ctrl_in = c;
    e = '0;
    e.vid = (m == 2'b01);
    for (int ch = 0; ch < NCH; ch++) begin
      e.sym[ch] = enc(ch, m, d[ch*8 +: 8], c[ch*2 +: 2]);
      e.dat[ch] = d[ch*8 +: 8];
      e.cnt[ch] = 8'(mcnt[ch]);
    end
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    exp_t e;
    mode_in = 2'b00;
    data_in = '0;
    ctrl_in = '0;
    rst_n   = 1'b0;
    #1;
    for (int ch = 0; ch < NCH; ch++) begin
      check_eq($sformatf("reset sym ch%0d", ch), int'(tmds_out[ch*10 +: 10]), int'(10'b1101010100));
      check_eq($sformatf("reset cnt ch%0d", ch), int'(dut.cnt_q[ch]), 0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    for (int ch = 0; ch < NCH; ch++) mcnt[ch] = 0;
    e = '0;
    for (int ch = 0; ch < NCH; ch++) e.sym[ch] = 10'b1101010100;
    exp_q.push_back(e);
    exp_q.push_back(e);
  endtask

  initial begin
    do_reset();

    for (int k = 0; k < 4; k++) begin
      logic [5:0] c;
      for (int ch = 0; ch < NCH; ch++) c[ch*2 +: 2] = 2'((k + ch) % 4);
      cycle(2'b00, 24'h0, c);
    end
    cycle(2'b11, 24'h0, 6'b111001);

    cycle(2'b01, 24'h000000, 6'h0);
    cycle(2'b01, 24'h000000, 6'h0);
    cycle(2'b00, 24'h0, 6'h0);
    cycle(2'b01, 24'hFFFFFF, 6'h0);
    cycle(2'b01, 24'hFFFFFF, 6'h0);

    cycle(2'b10, 24'h0F050F, 6'h0);
    cycle(2'b10, 24'h000F0A, 6'h0);
    cycle(2'b01, 24'h00FF10, 6'h0);
    cycle(2'b01, 24'h5AA53C, 6'h0);

    for (int n = 0; n < 10000; n++)
      cycle(2'b01, 24'($urandom), 6'h0);

    for (int n = 0; n < 600; n++)
      cycle(2'($urandom_range(0, 3)), 24'($urandom), 6'($urandom));

    cycle(2'b00, 24'h0, 6'h0);
    cycle(2'b01, 24'h000000, 6'h0);
    @(posedge clk);
    @(posedge clk);
    #2;
    for (int ch = 0; ch < NCH; ch++)
      check_eq($sformatf("pre-reset cnt ch%0d", ch), int'(dut.cnt_q[ch]), -8);
    do_reset();

    cycle(2'b01, 24'h000000, 6'h0);
    cycle(2'b01, 24'h00FF37, 6'h0);
    for (int n = 0; n < 50; n++)
      cycle(2'b01, 24'($urandom), 6'h0);
    cycle(2'b00, 24'h0, 6'h0);
    cycle(2'b00, 24'h0, 6'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
